// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer: FSM state encoding and
// the decoder enable patterns, packed as {Enable1_bar, Enable2_bar, Enable3}.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] DEC_ON    = 3'b001;
  localparam logic [2:0] DEC_OFF   = 3'b110;
  localparam logic [2:0] DEC_STALL = 3'b011;

  // A stalled decoder keeps E1b/E3 active but drops E2b, so every output is low.
  function automatic logic [2:0] dec_pattern(input state_t s);
    logic [2:0] p;
    case (s)
      RUN:     p = DEC_ON;
      STALL:   p = DEC_STALL;
      default: p = DEC_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Modulo-WIDTH_OUT phase counter with synchronous clear, synchronous zero and
// count enable. Wrap is compare-based so non-power-of-2 moduli never overrun.
module phase_counter #(
  parameter int WIDTH_OUT = 8,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
  input  logic                clk,
  input  logic                clear_bar,
  input  logic                zero,
  input  logic                count,
  output logic [WIDTH_IN-1:0] q,
  output logic                tc
);

  localparam logic [WIDTH_IN-1:0] LAST = WIDTH_IN'(WIDTH_OUT - 1);

  // Phase register: clear/zero dominate, otherwise count or hold.
  always_ff @(posedge clk) begin
    if (!clear_bar || zero) begin
      q <= '0;
    end else if (count) begin
      q <= (q == LAST) ? '0 : q + WIDTH_IN'(1);
    end else begin
      q <= q;
    end
  end

  assign tc = (q == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// T-state sequencer: drives the phase index and enables of a 3-to-8 phase
// decoder, with wait-state stalls, early end and boundary-only halt.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int WIDTH_OUT = 8,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
  input  logic                Clk,
  input  logic                Clear_bar,
  input  logic                Run,
  input  logic                Wait_bar,
  input  logic                End_bar,
  input  logic                Halt,
  output logic [WIDTH_IN-1:0] A,
  output logic                Enable1_bar,
  output logic                Enable2_bar,
  output logic                Enable3,
  output logic                Running,
  output logic                Cycle_done
);

  state_t     state_r;
  state_t     state_s;
  logic       zero_s;
  logic       count_s;
  logic       done_s;
  logic       tc;
  logic [2:0] enable_r;
  logic       running_r;
  logic       done_r;

  phase_counter #(
    .WIDTH_OUT(WIDTH_OUT),
    .WIDTH_IN (WIDTH_IN)
  ) u_counter (
    .clk      (Clk),
    .clear_bar(Clear_bar),
    .zero     (zero_s),
    .count    (count_s),
    .q        (A),
    .tc       (tc)
  );

  // Next-state and counter control; in RUN the wait request outranks any boundary.
  always_comb begin
    state_s = state_r;
    zero_s  = 1'b0;
    count_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE, HALTED: begin
        zero_s = 1'b1;
        if (Run && !(state_r == HALTED && Halt)) begin
          state_s = RUN;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (!Wait_bar) begin
          state_s = STALL;
        end else if (!End_bar || tc) begin
          zero_s = 1'b1;
          if (Halt) begin
            state_s = HALTED;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          count_s = 1'b1;
        end
      end
      STALL: begin
        if (Wait_bar) begin
          state_s = RUN;
        end else begin
          state_s = STALL;
        end
      end
      default: begin
        state_s = IDLE;
        zero_s  = 1'b1;
      end
    endcase
  end

  // State and registered output flags, all cleared synchronously.
  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      state_r   <= IDLE;
      enable_r  <= DEC_OFF;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      enable_r  <= dec_pattern(state_s);
      running_r <= (state_s == RUN) || (state_s == STALL);
      done_r    <= done_s;
    end
  end

  assign Enable1_bar = enable_r[2];
  assign Enable2_bar = enable_r[1];
  assign Enable3     = enable_r[0];
  assign Running     = running_r;
  assign Cycle_done  = done_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: WIDTH_OUT=8 and WIDTH_OUT=6 instances share stimulus
// and are compared every cycle against a behavioural model, plus directed pins.
module tb_phase_sequencer;

  logic       Clk = 1'b0;
  logic       Clear_bar, Run, Wait_bar, End_bar, Halt;
  logic [2:0] a8, a6;
  logic       e1b8, e2b8, e38, run8, cd8;
  logic       e1b6, e2b6, e36, run6, cd6;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_on   = 1'b0;

  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_HALTED = 3;

  typedef struct {
    int st;
    int a;
    bit cd;
  } mdl_t;

  mdl_t m8, m6;

  always #5 Clk = ~Clk;

  phase_sequencer #(.WIDTH_OUT(8)) dut8 (
    .Clk(Clk), .Clear_bar(Clear_bar), .Run(Run), .Wait_bar(Wait_bar),
    .End_bar(End_bar), .Halt(Halt), .A(a8), .Enable1_bar(e1b8),
    .Enable2_bar(e2b8), .Enable3(e38), .Running(run8), .Cycle_done(cd8)
  );

  phase_sequencer #(.WIDTH_OUT(6)) dut6 (
    .Clk(Clk), .Clear_bar(Clear_bar), .Run(Run), .Wait_bar(Wait_bar),
    .End_bar(End_bar), .Halt(Halt), .A(a6), .Enable1_bar(e1b6),
    .Enable2_bar(e2b6), .Enable3(e36), .Running(run6), .Cycle_done(cd6)
  );

  function automatic mdl_t mstep(mdl_t m, int w, bit clr_b, bit run, bit wait_b,
                                 bit end_b, bit halt);
    mdl_t n = m;
    n.cd = 1'b0;
    if (!clr_b) begin
      n.st = M_IDLE;
      n.a  = 0;
    end else if (m.st == M_IDLE || m.st == M_HALTED) begin
      n.a = 0;
      if (run && !(m.st == M_HALTED && halt)) n.st = M_RUN;
    end else if (m.st == M_RUN) begin
      if (!wait_b) begin
        n.st = M_STALL;
      end else if (!end_b || m.a == w - 1) begin
        n.a = 0;
        if (halt) n.st = M_HALTED;
        else n.cd = 1'b1;
      end else begin
        n.a = m.a + 1;
      end
    end else if (wait_b) begin
      n.st = M_RUN;
    end
    return n;
  endfunction

  // {E1b, E2b, E3} the decoder must see in a given model state
  function automatic int exp_en(int st);
    if (st == M_RUN) return 1;
    if (st == M_STALL) return 3;
    return 6;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge Clk) begin
    m8 = mstep(m8, 8, Clear_bar, Run, Wait_bar, End_bar, Halt);
    m6 = mstep(m6, 6, Clear_bar, Run, Wait_bar, End_bar, Halt);
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("m8_A", int'(a8), m8.a);
      chk("m8_en", int'({e1b8, e2b8, e38}), exp_en(m8.st));
      chk("m8_running", int'(run8), int'(m8.st == M_RUN || m8.st == M_STALL));
      chk("m8_cycle_done", int'(cd8), int'(m8.cd));
      chk("m6_A", int'(a6), m6.a);
      chk("m6_en", int'({e1b6, e2b6, e36}), exp_en(m6.st));
      chk("m6_running", int'(run6), int'(m6.st == M_RUN || m6.st == M_STALL));
      chk("m6_cycle_done", int'(cd6), int'(m6.cd));
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wait_a(int t);
    int n = 0;
    while (int'(a8) != t && n < 16) begin
      tick();
      n++;
    end
    chk("wait_for_phase", int'(a8), t);
  endtask

  initial begin
    m8 = '{M_IDLE, 0, 1'b0};
    m6 = '{M_IDLE, 0, 1'b0};
    Clear_bar = 1'b0; Run = 1'b0; Wait_bar = 1'b1; End_bar = 1'b1; Halt = 1'b0;
    @(negedge Clk);
    tick();
    chk_on = 1'b1;
    tick();

    // reset and idle hold
    Clear_bar = 1'b1;
    tick(); tick();
    chk("idle_A", int'(a8), 0);
    chk("idle_en", int'({e1b8, e2b8, e38}), 6);
    chk("idle_running", int'(run8), 0);

    // full sequence with wrap
    Run = 1'b1;
    tick();
    chk("run_start_A", int'(a8), 0);
    chk("run_start_cd", int'(cd8), 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("seq_A", int'(a8), k);
      chk("seq_cd", int'(cd8), 0);
    end
    tick();
    chk("wrap_A", int'(a8), 0);
    chk("wrap_cd", int'(cd8), 1);

    // early end at phase 3
    wait_a(3);
    End_bar = 1'b0;
    tick();
    End_bar = 1'b1;
    chk("end_A", int'(a8), 0);
    chk("end_cd", int'(cd8), 1);
    tick();
    chk("end_next_A", int'(a8), 1);

    // three-cycle stall at phase 5
    wait_a(5);
    Wait_bar = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_A", int'(a8), 5);
      chk("stall_e2b", int'(e2b8), 1);
    end
    Wait_bar = 1'b1;
    tick();
    chk("reissue_A", int'(a8), 5);
    chk("reissue_e2b", int'(e2b8), 0);
    tick();
    chk("after_stall_A", int'(a8), 6);

    // halt requested mid-instruction takes effect at the boundary
    wait_a(2);
    Halt = 1'b1;
    wait_a(7);
    tick();
    chk("halted_A", int'(a8), 0);
    chk("halted_running", int'(run8), 0);
    chk("halted_e1b", int'(e1b8), 1);
    tick();
    chk("halted_hold_running", int'(run8), 0);
    Halt = 1'b0;
    tick();
    chk("resume_running", int'(run8), 1);
    chk("resume_A", int'(a8), 0);

    // clear during a stall, then WIDTH_OUT=6 wrap
    wait_a(4);
    Wait_bar = 1'b0;
    tick();
    chk("pre_clear_e2b", int'(e2b8), 1);
    Clear_bar = 1'b0;
    tick();
    chk("clr_A", int'(a8), 0);
    chk("clr_running", int'(run8), 0);
    chk("clr_e3", int'(e38), 0);
    Clear_bar = 1'b1;
    Wait_bar = 1'b1;
    tick();
    chk("w6_start_A", int'(a6), 0);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk("w6_seq_A", int'(a6), k);
    end
    tick();
    chk("w6_wrap_A", int'(a6), 0);
    chk("w6_wrap_cd", int'(cd6), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Clear_bar = ($urandom_range(0, 49) != 0);
      Run       = ($urandom_range(0, 3) == 0);
      Wait_bar  = ($urandom_range(0, 4) != 0);
      End_bar   = ($urandom_range(0, 7) != 0);
      Halt      = ($urandom_range(0, 5) == 0);
      tick();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
